riscv_mult_wb_buf: RTL

Result-buffer stage directly downstream of the RI5CY multiplier (`riscv_mult`).
- Captures each completed multiplier result with its destination register tag in a 2-entry in-order skid buffer.
- Presents results to the register-file write port with a valid/ready handshake.
- Optionally forwards buffered results to operand read.
- Decouples the multiplier from write-port arbitration stalls, so a finished MUL_H / MAC result need not hold the EX stage.

---
 rtl/riscv_mult_wb_pkg.sv | 21 ++
 rtl/riscv_mult_wb_fwd.sv | 37 +++
 rtl/riscv_mult_wb_buf.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/riscv_mult_wb_pkg.sv
// Shared types and constants for the multiplier result write-back buffer.
package riscv_mult_wb_pkg;

  localparam int unsigned MULT_WB_DEPTH  = 2;
  localparam int unsigned MULT_WB_DATA_W = 32;
  localparam int unsigned MULT_WB_ADDR_W = 5;

  // Buffer occupancy
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  // One buffered result at the default core widths
  typedef struct packed {
    logic [MULT_WB_ADDR_W-1:0] rd;
    logic [MULT_WB_DATA_W-1:0] data;
  } mult_wb_entry_t;

endpackage

// File: rtl/riscv_mult_wb_fwd.sv
// Two-entry tag compare with youngest-match select for operand forwarding.
// Only compiled when RISCV_MULT_WB_FWD_EN is defined.
`ifdef RISCV_MULT_WB_FWD_EN
module riscv_mult_wb_fwd
  import riscv_mult_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0]    raddr_i,
  input  logic [MULT_WB_DEPTH-1:0] vld_i,
  input  logic [ADDR_WIDTH-1:0]    rd0_i,
  input  logic [DATA_WIDTH-1:0]    data0_i,
  input  logic [ADDR_WIDTH-1:0]    rd1_i,
  input  logic [DATA_WIDTH-1:0]    data1_i,
  output logic                     hit_o,
  output logic [DATA_WIDTH-1:0]    data_o
);

  // Entry 1 is younger, so it is checked last and overrides entry 0
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    if (raddr_i != '0) begin
      if (vld_i[0] && (rd0_i == raddr_i)) begin
        hit_o  = 1'b1;
        data_o = data0_i;
      end
      if (vld_i[1] && (rd1_i == raddr_i)) begin
        hit_o  = 1'b1;
        data_o = data1_i;
      end
    end
  end

endmodule
`endif

// File: rtl/riscv_mult_wb_buf.sv
// 2-entry in-order skid buffer between riscv_mult and the register-file write port.
// Optional operand forwarding is enabled by defining RISCV_MULT_WB_FWD_EN.
module riscv_mult_wb_buf
  import riscv_mult_wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  mult_valid_i,
  input  logic [DATA_WIDTH-1:0] mult_result_i,
  input  logic [ADDR_WIDTH-1:0] mult_rd_i,
  output logic                  mult_ready_o,
  output logic                  wb_valid_o,
  output logic [ADDR_WIDTH-1:0] wb_rd_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic                  wb_ready_i,
  input  logic [ADDR_WIDTH-1:0] fwd_raddr_i,
  output logic                  fwd_hit_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o
);

  localparam logic [1:0] ST_EMPTY = OCC_EMPTY;
  localparam logic [1:0] ST_ONE   = OCC_ONE;
  localparam logic [1:0] ST_TWO   = OCC_TWO;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [1:0] state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic       wb_valid_q, wb_valid_d;
  logic       ready_q, ready_d;
  entry_t     in_entry;
  logic       push, pop;

  assign in_entry = '{rd: mult_rd_i, data: mult_result_i};

  // x0 results are acknowledged but never stored
  assign push = mult_valid_i & ready_q & (mult_rd_i != '0);
  assign pop  = wb_valid_q & wb_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_d  = in_entry;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            tail_d  = in_entry;
            state_d = ST_TWO;
          end else if (pop && !push) begin
            state_d = ST_EMPTY;
          end else if (push && pop) begin
            head_d  = in_entry;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    // Handshake flags are registered from the next occupancy
    wb_valid_d = (state_d != ST_EMPTY);
    ready_d    = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      wb_valid_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      wb_valid_q <= wb_valid_d;
      ready_q    <= ready_d;
    end
  end

  assign mult_ready_o = ready_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_rd_o      = head_q.rd;
  assign wb_data_o    = head_q.data;

`ifdef RISCV_MULT_WB_FWD_EN
  logic [MULT_WB_DEPTH-1:0] fwd_vld;
  assign fwd_vld = {(state_q == ST_TWO), wb_valid_q};

  riscv_mult_wb_fwd #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fwd (
    .raddr_i (fwd_raddr_i),
    .vld_i   (fwd_vld),
    .rd0_i   (head_q.rd),
    .data0_i (head_q.data),
    .rd1_i   (tail_q.rd),
    .data1_i (tail_q.data),
    .hit_o   (fwd_hit_o),
    .data_o  (fwd_data_o)
  );
`else
  logic unused_fwd_raddr;
  assign unused_fwd_raddr = ^fwd_raddr_i;
  assign fwd_hit_o        = 1'b0;
  assign fwd_data_o       = '0;
`endif

`ifndef SYNTHESIS
  // A result offered while the buffer is full is lost
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(mult_valid_i && !ready_q)
  );
`endif

endmodule
